// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU and its command sequencer.
// Op encodings, datapath widths and the sequencer state enum.
package alu_pkg;

  localparam int ALU_IN_W  = 4;
  localparam int ALU_OUT_W = 9;
  localparam int ALU_OP_W  = 3;
  localparam int RES_W     = ALU_OP_W + ALU_OUT_W;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_OR  = 3'd4,
    OP_ROL = 3'd5,
    OP_ROR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU with a 9-bit zero-extended result.
// Result width depends on the op: 5b add/sub, 4b logic/rotate, 8b mul.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]  op,
  input  logic [ALU_IN_W-1:0]  in1,
  input  logic [ALU_IN_W-1:0]  in2,
  output logic [ALU_OUT_W-1:0] out
);

  logic [4:0] sum;
  logic [4:0] dif;
  logic [7:0] prod;
  logic [7:0] dbl;
  logic [7:0] rot_l;
  logic [7:0] rot_r;

  always_comb begin
    sum   = {1'b0, in1} + {1'b0, in2};
    dif   = {1'b0, in1} - {1'b0, in2};
    prod  = {4'b0, in1} * {4'b0, in2};
    // Rotate by shifting a doubled copy; only amt mod 4 matters.
    dbl   = {in1, in1};
    rot_l = dbl << in2[1:0];
    rot_r = dbl >> in2[1:0];
    out   = '0;
    unique case (op)
      OP_ADD: out = {4'b0, sum};
      OP_SUB: out = {4'b0, dif};
      OP_AND: out = {5'b0, in1 & in2};
      OP_XOR: out = {5'b0, in1 ^ in2};
      OP_OR:  out = {5'b0, in1 | in2};
      OP_ROL: out = {5'b0, rot_l[7:4]};
      OP_ROR: out = {5'b0, rot_r[3:0]};
      OP_MUL: out = {1'b0, prod};
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO, {op,data} entries, wrap-bit pointers.
// Head reads as zero while empty.
module alu_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_pop;
  logic         do_push;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full push needs.
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives one ALU from a valid/ready command port and queues results.
// Tracks completed ops and a sticky add/sub carry-borrow flag.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_WAIT  = 2,
  parameter int RES_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_in1,
  input  logic [3:0]       cmd_in2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [8:0]       res_data,
  output logic [2:0]       res_op,
  output logic [CNT_W-1:0] op_count,
  output logic             carry_sticky,
  input  logic             clr_sticky
);

  localparam int WAIT_W = $clog2(MUL_WAIT + 2);
  localparam logic [WAIT_W-1:0] MUL_LOAD = WAIT_W'(MUL_WAIT);

  seq_state_e           state_q, state_d;
  logic [ALU_OP_W-1:0]  op_q, op_d;
  logic [ALU_IN_W-1:0]  a_q, a_d;
  logic [ALU_IN_W-1:0]  b_q, b_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 rdy_en_q;

  logic [ALU_OUT_W-1:0] alu_out;
  logic [RES_W-1:0]     fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;

  alu u_alu (
    .op  (op_q),
    .in1 (a_q),
    .in2 (b_q),
    .out (alu_out)
  );

  alu_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (RES_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({op_q, alu_out}),
    .pop   (res_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_valid    = !fifo_empty;
  assign res_op       = fifo_rdata[RES_W-1:ALU_OUT_W];
  assign res_data     = fifo_rdata[ALU_OUT_W-1:0];
  assign op_count     = cnt_q;
  assign carry_sticky = sticky_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q && !clr_sticky;
    fifo_push = 1'b0;
    // Admission checks FIFO space, so WRITE never meets a full FIFO.
    cmd_ready = (state_q == ST_IDLE) && !fifo_full && rdy_en_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          a_d     = cmd_in1;
          b_d     = cmd_in2;
          wait_d  = (cmd_op == OP_MUL) ? MUL_LOAD : '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        fifo_push = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if ((op_q == OP_ADD || op_q == OP_SUB) && alu_out[4]) begin
          sticky_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with directed vectors.
// Expected results are hand-computed and queued at command handshake.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_in1 = '0;
  logic [3:0]  cmd_in2 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [8:0]  res_data;
  logic [2:0]  res_op;
  logic [15:0] op_count;
  logic        carry_sticky;
  logic        clr_sticky = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int hs_cyc = 0;
  int lat;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;

  alu_cmd_sequencer #(
    .MUL_WAIT  (2),
    .RES_DEPTH (4),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_in1      (cmd_in1),
    .cmd_in2      (cmd_in2),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_op       (res_op),
    .op_count     (op_count),
    .carry_sticky (carry_sticky),
    .clr_sticky   (clr_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare the FIFO head whenever it is taken.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(res_data), 32'h1ff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_data", 32'(res_data), 32'(mon_e[8:0]));
        chk("res_op", 32'(res_op), 32'(mon_e[11:9]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [8:0] exp_d);
    bit ok = 1'b0;
    cmd_op    = op;
    cmd_in1   = a;
    cmd_in2   = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        hs_cyc = cyc;
        exp_q.push_back({op, exp_d});
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int l);
    bit ok = 1'b0;
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) begin
        l = cyc - hs_cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_sticky", 32'(carry_sticky), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_op", 32'(res_op), 32'd0);
    @(posedge clk);
    #1;
    chk("cmd_ready_after_rel", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;

    send_cmd(3'd0, 4'h9, 4'h8, 9'h011);
    wait_valid(lat);
    chk("lat_add", 32'(lat), 32'd3);
    drain();
    chk("sticky_add", 32'(carry_sticky), 32'd1);
    chk("cnt_add", 32'(op_count), 32'd1);

    send_cmd(3'd1, 4'h3, 4'h5, 9'h01e);
    drain();
    chk("sticky_sub", 32'(carry_sticky), 32'd1);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_clr", 32'(carry_sticky), 32'd0);
    send_cmd(3'd2, 4'hc, 4'ha, 9'h008);
    drain();
    chk("sticky_and", 32'(carry_sticky), 32'd0);

    // Clear held across the setting write: set must win.
    clr_sticky = 1'b1;
    send_cmd(3'd0, 4'hf, 4'h1, 9'h010);
    wait_valid(lat);
    chk("sticky_set_wins", 32'(carry_sticky), 32'd1);
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_clr_after", 32'(carry_sticky), 32'd0);
    drain();

    send_cmd(3'd7, 4'hf, 4'hf, 9'h0e1);
    wait_valid(lat);
    chk("lat_mul", 32'(lat), 32'd5);
    drain();

    send_cmd(3'd5, 4'h9, 4'h1, 9'h003);
    send_cmd(3'd6, 4'h9, 4'h5, 9'h00c);
    send_cmd(3'd3, 4'hf, 4'h5, 9'h00a);
    send_cmd(3'd4, 4'h1, 4'h8, 9'h009);
    drain();
    chk("cnt_9", 32'(op_count), 32'd9);

    res_ready = 1'b0;
    send_cmd(3'd0, 4'h1, 4'h2, 9'h003);
    send_cmd(3'd1, 4'h9, 4'h1, 9'h008);
    send_cmd(3'd2, 4'h7, 4'he, 9'h006);
    send_cmd(3'd6, 4'h8, 4'h2, 9'h002);
    fork
      send_cmd(3'd7, 4'h3, 4'h4, 9'h00c);
    join_none
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_cmd_pending", 32'(cmd_valid), 32'd1);
    chk("full_res_valid", 32'(res_valid), 32'd1);
    chk("full_cnt", 32'(op_count), 32'd13);
    chk("full_head", 32'(res_data), 32'h003);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();
    chk("cnt_14", 32'(op_count), 32'd14);

    res_ready = 1'b0;
    send_cmd(3'd0, 4'h2, 4'h2, 9'h004);
    send_cmd(3'd0, 4'h3, 4'h3, 9'h006);
    send_cmd(3'd7, 4'h5, 4'h5, 9'h019);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_cnt", 32'(op_count), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    chk("post_rst_cnt", 32'(op_count), 32'd0);
    chk("post_rst_data", 32'(res_data), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    send_cmd(3'd0, 4'h1, 4'h1, 9'h002);
    wait_valid(lat);
    chk("lat_post_rst", 32'(lat), 32'd3);
    drain();
    chk("cnt_post_rst", 32'(op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
